// File: rtl/btc_nonce_scan.sv
// btc_nonce_scan: issues sequential nonces into the double-SHA256 pipeline and
// queues nonces whose final hash word equals TARGET in a small golden FIFO.
module btc_nonce_scan #(
  parameter int          LATENCY = 128,
  parameter logic [31:0] TARGET  = 32'ha41f32e7,
  parameter int          DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] start_nonce,
  input  logic        run,
  input  logic [31:0] hash_in,
  output logic [31:0] nonce_out,
  output logic        issue_valid,
  output logic        exhausted,
  output logic [31:0] golden_nonce,
  output logic        golden_valid,
  input  logic        golden_rd,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]        next_nonce, check_nonce;
  logic [LATENCY-1:0] vline;
  logic [31:0]        mem [DEPTH];
  logic [AW:0]        wp, rp;
  logic [AW-1:0]      head;
  logic               check_valid, hit, empty, full, pop, push;
  assign check_valid  = vline[LATENCY-1];
  assign hit          = check_valid && hash_in == TARGET && !load;
  assign empty        = wp == rp;
  assign full         = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign pop          = golden_rd && !empty;
  assign push         = hit && (!full || pop);
  assign golden_valid = !empty;
  // When empty, keep showing the most recently popped entry.
  assign head         = rp[AW-1:0] - AW'(empty);
  assign golden_nonce = mem[head];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nonce_out   <= '0;
      issue_valid <= 1'b0;
      exhausted   <= 1'b0;
      overflow    <= 1'b0;
      next_nonce  <= '0;
      check_nonce <= '0;
      vline       <= '0;
      wp          <= '0;
      rp          <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) rp <= rp + 1'b1;
      if (push) begin
        mem[wp[AW-1:0]] <= check_nonce;
        wp              <= wp + 1'b1;
      end
      if (load) begin
        nonce_out   <= start_nonce;
        next_nonce  <= start_nonce;
        check_nonce <= start_nonce;
        issue_valid <= 1'b0;
        exhausted   <= 1'b0;
        overflow    <= 1'b0;
        vline       <= '0;
      end else begin
        vline <= {vline[LATENCY-2:0], issue_valid};
        if (check_valid) check_nonce <= check_nonce + 32'd1;
        if (hit && full && !pop) overflow <= 1'b1;
        if (run && !exhausted) begin
          nonce_out   <= next_nonce;
          issue_valid <= 1'b1;
          next_nonce  <= next_nonce + 32'd1;
          if (next_nonce == 32'hffffffff) exhausted <= 1'b1;
        end else begin
          issue_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_btc_nonce_scan.sv
// tb_btc_nonce_scan: scenario sequences, a wrap vector table and random traffic
// checked cycle by cycle against a queue-based model of issue, checks and FIFO.
module tb_btc_nonce_scan;
  localparam int          L = 8;
  localparam int          D = 4;
  localparam logic [31:0] T = 32'ha41f32e7;
  localparam logic [31:0] K = 32'h5a5a5a5a;
  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, run = 1'b0, golden_rd = 1'b0;
  logic [31:0] start_nonce = '0, hash_in, nonce_out, golden_nonce;
  logic        issue_valid, exhausted, golden_valid, overflow;
  logic [31:0] pipe [L];
  logic [31:0] lo = 32'd1, hi = 32'd0, h1 = 32'h12345678;
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  typedef struct { int due; logic [31:0] n; } fl_t;
  fl_t         fl [$];
  logic [31:0] gq [$];
  logic [31:0] got [$];
  logic [31:0] m_nonce, m_next, m_last;
  logic        m_iv, m_exh, m_ovf;
  typedef struct { logic ld; logic [31:0] st; logic rn; logic [31:0] en; logic eiv, eex; } vec_t;
  vec_t tv [6];

  btc_nonce_scan #(.LATENCY(L), .TARGET(T), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .start_nonce(start_nonce), .run(run),
    .hash_in(hash_in), .nonce_out(nonce_out), .issue_valid(issue_valid),
    .exhausted(exhausted), .golden_nonce(golden_nonce), .golden_valid(golden_valid),
    .golden_rd(golden_rd), .overflow(overflow));

  always #5 clk = ~clk;

  // External hash pipeline: fixed delay of nonce_out, hitting only the chosen nonces.
  initial for (int i = 0; i < L; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= nonce_out;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign hash_in = (pipe[L-1] == h1 || (pipe[L-1] >= lo && pipe[L-1] <= hi)) ? T : pipe[L-1] ^ K;

  function automatic logic [31:0] hfun(input logic [31:0] n);
    return (n == h1 || (n >= lo && n <= hi)) ? T : n ^ K;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic step();
    logic [31:0] n;
    logic        hit, full, pop;
    fl_t         e;
    n = '0;
    if (!rst_n) begin
      m_nonce = '0; m_next = '0; m_iv = 0; m_exh = 0; m_ovf = 0; m_last = '0;
      gq.delete(); fl.delete();
    end else begin
      hit = 0;
      if (!load && fl.size() > 0 && fl[0].due == cyc) begin
        e = fl.pop_front();
        n = e.n;
        hit = hfun(n) == T;
      end
      full = gq.size() == D;
      pop  = golden_rd && gq.size() > 0;
      if (pop) m_last = gq.pop_front();
      if (hit) begin
        if (!full || pop) gq.push_back(n);
        else m_ovf = 1;
      end
      if (load) begin
        m_nonce = start_nonce; m_next = start_nonce; m_iv = 0; m_exh = 0; m_ovf = 0;
        fl.delete();
      end else if (run && !m_exh) begin
        m_nonce = m_next; m_iv = 1; m_exh = m_next == 32'hffffffff; m_next = m_next + 1;
        fl.push_back('{cyc + 1 + L, m_nonce});
      end else begin
        m_iv = 0;
      end
    end
    @(posedge clk); #1;
    cyc++;
    chk("nonce_out", nonce_out, m_nonce);
    chk("issue_valid", issue_valid, m_iv);
    chk("exhausted", exhausted, m_exh);
    chk("golden_valid", golden_valid, gq.size() > 0);
    chk("golden_nonce", golden_nonce, gq.size() > 0 ? gq[0] : m_last);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic pop_step();
    if (golden_valid) got.push_back(golden_nonce);
    golden_rd = 1; step(); golden_rd = 0;
  endtask

  task automatic do_load(input logic [31:0] s);
    load = 1; start_nonce = s; step(); load = 0;
  endtask

  initial begin
    int c0;
    tv[0] = '{1'b1, 32'hfffffffe, 1'b0, 32'hfffffffe, 1'b0, 1'b0};
    tv[1] = '{1'b0, 32'h0,        1'b1, 32'hfffffffe, 1'b1, 1'b0};
    tv[2] = '{1'b0, 32'h0,        1'b1, 32'hffffffff, 1'b1, 1'b1};
    tv[3] = '{1'b0, 32'h0,        1'b1, 32'hffffffff, 1'b0, 1'b1};
    tv[4] = '{1'b0, 32'h0,        1'b1, 32'hffffffff, 1'b0, 1'b1};
    tv[5] = '{1'b0, 32'h0,        1'b0, 32'hffffffff, 1'b0, 1'b1};
    step(); rst_n = 1;
    chk("rst_golden_nonce", golden_nonce, 32'h0);
    // Single hit: golden_valid rises 9 cycles after nonce 100 is issued.
    lo = 100; hi = 100;
    do_load(100);
    run = 1; step(); c0 = cyc;
    chk("single_issue", nonce_out, 32'd100);
    for (int i = 0; i < 20 && !golden_valid; i++) step();
    chk("single_latency", cyc - c0, 32'd9);
    chk("single_value", golden_nonce, 32'd100);
    run = 0; repeat (L + 2) step();
    pop_step();
    chk("single_only", golden_valid, 1'b0);
    // Run gaps: stale nonce_out repeats must not produce extra entries.
    lo = 5; hi = 5;
    do_load(0);
    for (int i = 0; i < 24; i++) begin run = (i % 3 == 0); step(); end
    run = 0; repeat (L + 2) step();
    chk("gap_valid", golden_valid, 1'b1);
    chk("gap_value", golden_nonce, 32'd5);
    pop_step();
    chk("gap_single", golden_valid, 1'b0);
    // Overflow: six consecutive hits, no reads.
    lo = 1000; hi = 1005;
    do_load(1000);
    run = 1; repeat (6) step(); run = 0;
    repeat (L + 3) step();
    chk("ovf_flag", overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order", golden_nonce, 1000 + k);
      pop_step();
    end
    chk("ovf_drained", golden_valid, 1'b0);
    chk("ovf_hold_last", golden_nonce, 32'd1003);
    // Push and pop together while full.
    lo = 2000; hi = 2005; got.delete();
    do_load(2000);
    chk("load_clears_ovf", overflow, 1'b0);
    run = 1; repeat (6) step(); run = 0;
    for (int i = 0; i < L + 6; i++) if (gq.size() == D) pop_step(); else step();
    chk("fullpop_ovf", overflow, 1'b0);
    for (int i = 0; i < 8 && golden_valid; i++) pop_step();
    chk("fullpop_count", got.size(), 32'd6);
    for (int k = 0; k < got.size(); k++) chk("fullpop_order", got[k], 2000 + k);
    // Wrap at the top of the nonce space.
    lo = 1; hi = 0; h1 = 32'h12345678;
    for (int i = 0; i < 6; i++) begin
      load = tv[i].ld; start_nonce = tv[i].st; run = tv[i].rn;
      step();
      chk("wrap_nonce", nonce_out, tv[i].en);
      chk("wrap_issue", issue_valid, tv[i].eiv);
      chk("wrap_exhausted", exhausted, tv[i].eex);
    end
    load = 0; run = 0;
    // Load mid-flight discards the in-flight hit on 300; old entry 10 survives.
    lo = 10; hi = 10;
    do_load(10);
    run = 1; step(); run = 0;
    repeat (L + 2) step();
    lo = 300; hi = 300; h1 = 503;
    do_load(295);
    run = 1;
    for (int i = 0; i < 20 && !(issue_valid && nonce_out == 300); i++) step();
    c0 = cyc;
    for (int i = 0; i < 20 && cyc < c0 + L - 3; i++) step();
    do_load(500);
    run = 1; repeat (6) step(); run = 0;
    repeat (L + 3) step();
    chk("mid_ovf", overflow, 1'b0);
    chk("mid_old", golden_nonce, 32'd10);
    pop_step();
    chk("mid_new", golden_nonce, 32'd503);
    pop_step();
    chk("mid_empty", golden_valid, 1'b0);
    // Reset while two entries are held and hits are still in flight.
    h1 = 600; lo = 602; hi = 620;
    do_load(598);
    run = 1;
    for (int i = 0; i < 40 && gq.size() < 2; i++) step();
    chk("pre_rst_entries", gq.size(), 32'd2);
    rst_n = 0; step(); rst_n = 1;
    chk("rst_nonce", nonce_out, 32'h0);
    chk("rst_issue", issue_valid, 1'b0);
    chk("rst_valid", golden_valid, 1'b0);
    chk("rst_gnonce", golden_nonce, 32'h0);
    chk("rst_ovf", overflow, 1'b0);
    repeat (L + 2) begin step(); chk("rst_nohit", golden_valid, 1'b0); end
    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      load = $urandom_range(0, 39) == 0;
      if (load) begin
        start_nonce = ($urandom_range(0, 3) == 0) ? 32'hffffffff - $urandom_range(0, 30) : $urandom;
        lo = start_nonce + $urandom_range(0, 20);
        hi = lo + $urandom_range(0, 7);
        h1 = start_nonce + $urandom_range(0, 40);
      end
      run       = $urandom_range(0, 3) != 0;
      golden_rd = $urandom_range(0, 2) == 0;
      rst_n     = $urandom_range(0, 299) != 0;
      step();
    end
    rst_n = 1; load = 0; run = 0; golden_rd = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/btc_nonce_scan.md
# btc_nonce_scan

Nonce sequencer and golden-nonce detector wrapped around the double-SHA256 hash pipeline (`sha256_pipe66` into `sha256_pipe62`). It issues one nonce per clock into the data word of the first pipe. It tracks which issued nonces are in flight through the fixed-latency pipeline, and compares the final 32-bit hash word against a target. Matching nonces are queued in a small FIFO that the host interface drains.

## Interface

**Parameters**
- `LATENCY`, default 128: clocks from `nonce_out` to the matching `hash_in` (66 + 62). Must be ≥ 2.
- `TARGET`, default 32'ha41f32e7: `hash_in` value that constitutes a hit.
- `DEPTH`, default 4: golden FIFO entries. Must be a power of two, ≥ 2.

**Ports**
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous active-low reset. Sampled on the `clk` rising edge.
- `load` in 1: one-cycle pulse that starts new work. Priority over `run`.
- `start_nonce` in 32: first nonce of the new work. Sampled when `load`=1.
- `run` in 1: permits nonce issue. Level-sensitive.
- `hash_in` in 32: final hash word from the pipeline (`sha256_pipe62.hash`).
- `nonce_out` out 32: nonce driven into the pipeline data word.
- `issue_valid` out 1: `nonce_out` is a fresh, counted nonce this cycle.
- `exhausted` out 1: nonce space wrapped; issue halted until the next `load`.
- `golden_nonce` out 32: head of the golden FIFO.
- `golden_valid` out 1: FIFO non-empty.
- `golden_rd` in 1: pop the FIFO head. Ignored when empty.
- `overflow` out 1: sticky flag; a hit was dropped because the FIFO was full.

## Operation

**Reset** (`rst_n`=0 at an edge):
- `nonce_out`=0, `issue_valid`=0, `exhausted`=0.
- FIFO empty, so `golden_valid`=0 and `golden_nonce`=0.
- `overflow`=0.
- Valid delay line cleared; internal `next_nonce`=0 and `check_nonce`=0.

**Load** (priority over everything except reset):
- `nonce_out`←`start_nonce`, `next_nonce`←`start_nonce`, `check_nonce`←`start_nonce`.
- `issue_valid`←0, `exhausted`←0, `overflow`←0.
- Whole delay line cleared, so all in-flight results are discarded.
- FIFO contents are kept; the host still drains hits from the previous work.

**Issue** (`run`=1, `exhausted`=0, `load`=0):
- `nonce_out`←`next_nonce`, `issue_valid`←1, `next_nonce`←`next_nonce`+1.
- If the issued value is 32'hffffffff, then `exhausted`←1 and `next_nonce` wraps to 0. No further issue occurs.
- Otherwise `issue_valid`←0 and `nonce_out` holds its value (the pipeline recomputes a stale nonce, which is not checked).

**Tracking**:
- `issue_valid` enters a `LATENCY`-bit shift register; its output tap is `check_valid`.
- `check_nonce` increments by 1 (mod 2^32) on every cycle where `check_valid`=1. Because issue is strictly sequential, `check_nonce` always equals the nonce whose hash is on `hash_in`.

**Hit**:
- A hit is `check_valid`=1 and `hash_in`==`TARGET`.
- A hit pushes `check_nonce` into the FIFO.
- If the FIFO is full and no pop occurs the same cycle, the hit is dropped and `overflow`←1.

**FIFO**:
- Read and write pointers are log2(DEPTH)+1 bits wide with wrap-around.
- Simultaneous push and pop is legal in every state:
  - When full, the pop frees a slot and the push is accepted; no overflow.
  - When empty, the push is stored and the pop is ignored.
- `golden_nonce` shows the head entry combinationally from the storage array, and holds its last value when empty.

## Timing

- `nonce_out`/`issue_valid` update one edge after `run` is sampled high, or one edge after `load`.
- The nonce issued in cycle c is checked against `hash_in` in cycle c+`LATENCY`.
- A hit detected in cycle c+`LATENCY` makes `golden_valid` high in cycle c+`LATENCY`+1. This is also the earliest cycle in which the hit can be popped.
- After `golden_rd`=1 is sampled, the next entry (or `golden_valid`=0) appears in the following cycle.
- A `load` in cycle k suppresses every check through cycle k+`LATENCY`. The first nonce issued after the load, in cycle k+1 or later, is checked no earlier than cycle k+1+`LATENCY`.
- Reset mid-operation: all state returns to its reset value at the sampling edge. The pipeline's in-flight results are never checked.
- Throughput: one nonce per clock while `run`=1. No bubbles are inserted by the block.

## Test plan

Use `LATENCY`=8, `DEPTH`=4, and model the pipeline as an 8-deep delay of `nonce_out` XOR 32'h5a5a5a5a. Set `TARGET` to the value that yields a hit on the chosen nonce.

- **Single hit:** `load` with `start_nonce`=100, `run`=1, `TARGET`=100^5a5a5a5a → `golden_valid` rises exactly 9 cycles after `nonce_out`=100 is issued. `golden_nonce`=100, no other entries.
- **Run gaps:** `start_nonce`=0, `run` toggling 1,0,0,1,… with the target hit on nonce 5 → exactly one entry, value 5. No entry for the repeated stale `nonce_out` values.
- **Overflow and FIFO behaviour:**
  - Force `TARGET` to match 6 consecutive nonces (model XOR=0, `TARGET` range via bench override) with no reads → FIFO holds the first 4 nonces and `overflow`=1.
  - Then `golden_rd` 4 times → entries appear in order, then `golden_valid`=0.
  - Simultaneous push and pop while full → no overflow and order is preserved.
- **Wrap:** `start_nonce`=32'hfffffffe, `run`=1 → issues fffffffe then ffffffff. `exhausted`=1 from the next cycle; `issue_valid` stays 0 thereafter.
- **Load mid-flight:** a hit nonce is in flight when `load` (`start_nonce`=500) is pulsed 3 cycles before its check → no FIFO entry and `overflow` cleared. Old FIFO entries remain; the new hit at 503 arrives normally.
- **Reset mid-operation:** `rst_n`=0 for 1 cycle while the FIFO holds 2 entries and issue is running → all outputs at their reset values the next cycle. No spurious hit within the following `LATENCY` cycles.
